// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared types and constants for the RAM read sequencer
package ram_rd_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        OUTPUT,
        DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ram_rd_timer.sv
// rtl/ram_rd_timer.sv - loadable down-counter with zero flag for phase timing
module ram_rd_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ram_read_sequencer.sv
// rtl/ram_read_sequencer.sv - sweeps a RAM address range with timed RD strobes and streams the words out
// Optional capture checker enabled by RAM_RD_CHECK_EN.
module ram_read_sequencer
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 4
`ifdef RAM_RD_CHECK_EN
    ,
    parameter int EXP_OFFSET = 5
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready
`ifdef RAM_RD_CHECK_EN
    ,
    output logic [ADDR_W:0]   err_cnt,
    output logic              err_flag
`endif
);

    localparam int MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     remaining;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;
    logic                last_word;

    assign last_word = (remaining == (ADDR_W+1)'(1));

    // The timer is loaded with N-1 on phase entry, so each phase lasts exactly N cycles.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: if (start && count != '0) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETUP_CYC - 1);
            end
            SETUP: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(PULSE_CYC - 1);
            end
            STROBE: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(HOLD_CYC - 1);
            end
            OUTPUT: if (out_ready && !last_word) begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETUP_CYC - 1);
            end
            default: ;
        endcase
    end

    ram_rd_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

`ifdef RAM_RD_CHECK_EN
    localparam logic [ADDR_W:0] ERR_MAX = (ADDR_W+1)'(2 ** ADDR_W);
    logic [DATA_W-1:0] exp_word;
    assign exp_word = DATA_W'(EXP_OFFSET + int'(cur_addr));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
`ifdef RAM_RD_CHECK_EN
            err_cnt   <= '0;
            err_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= count;
                        busy      <= 1'b1;
`ifdef RAM_RD_CHECK_EN
                        err_cnt   <= '0;
                        err_flag  <= 1'b0;
`endif
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            ram_addr <= base_addr;
                        end
                    end
                end
                SETUP: begin
                    if (tmr_zero) begin
                        state  <= STROBE;
                        ram_rd <= 1'b1;
                    end
                end
                STROBE: begin
                    // Capture on the final strobe cycle, while RD is still asserted.
                    if (tmr_zero) begin
                        state    <= HOLD;
                        ram_rd   <= 1'b0;
                        out_data <= ram_data;
                        out_addr <= cur_addr;
`ifdef RAM_RD_CHECK_EN
                        if (ram_data != exp_word) begin
                            err_flag <= 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                HOLD: begin
                    if (tmr_zero) begin
                        state     <= OUTPUT;
                        out_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= SETUP;
                            cur_addr <= cur_addr + 1'b1;
                            ram_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_read_sequencer.md
Name: ram_read_sequencer

Overview:
Read-side master for the 16x4 asynchronous-strobe RAM. The write path fills the RAM with WR pulses. This block sweeps a programmable address range, issues timed RD strobes, and captures dataOUT. It streams each captured word out over a valid/ready handshake. It sits between the RAM and any consumer, such as a display driver or a checker.

Parameters:
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W.
- DATA_W, 4, RAM data width.
- SETUP_CYC, 1, cycles ram_addr is held stable before ram_rd rises (min 1).
- PULSE_CYC, 4, cycles ram_rd is held high (min 1).
- HOLD_CYC, 4, cycles after ram_rd falls before ram_addr may change (min 1).

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- base_addr  in  ADDR_W  first address; latched on an accepted start.
- count  in  ADDR_W+1  number of words to read, 0..16; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse when the sweep completes.
- ram_addr  out  ADDR_W  address to the RAM addr input.
- ram_rd  out  1  read strobe to the RAM RD input.
- ram_data  in  DATA_W  RAM dataOUT.
- out_data  out  DATA_W  captured word.
- out_addr  out  ADDR_W  address the word came from.
- out_valid  out  1  out_data and out_addr are valid.
- out_ready  in  1  consumer accepts the word when valid and ready are both high.

Behaviour:
- Reset values: busy=0, done=0, ram_rd=0, ram_addr=0, out_valid=0, out_data=0, out_addr=0. State is IDLE and all counters are 0.
- Reset mid-sweep aborts on the next edge. ram_rd drops the same cycle and no done pulse is issued.
- State machine: IDLE -> SETUP -> STROBE -> HOLD -> OUTPUT -> (SETUP | DONE) -> IDLE.
- IDLE: when start=1, latch base_addr into cur_addr and count into remaining.
  - If count=0: go to DONE directly. No RAM access, and done pulses 1 cycle after start.
  - Otherwise go to SETUP, with ram_addr=cur_addr registered.
- SETUP: stay SETUP_CYC cycles with ram_rd=0, then go to STROBE.
- STROBE: ram_rd=1 for PULSE_CYC cycles. On the last STROBE cycle, ram_data is registered into out_data and cur_addr into out_addr.
- HOLD: ram_rd=0 and ram_addr unchanged for HOLD_CYC cycles.
- OUTPUT: out_valid=1.
  - Stay in OUTPUT until out_ready=1. out_data and out_addr stay stable while stalled.
  - On handshake: out_valid=0 next cycle and remaining is decremented.
  - If remaining becomes 0, go to DONE. Otherwise cur_addr=cur_addr+1 modulo 2**ADDR_W and go to SETUP.
- Address wrap: 15 increments to 0, e.g. base=14, count=4 reads 14, 15, 0, 1. count=16 reads every location exactly once.
- DONE: done=1 for one cycle, busy=0 on the following cycle, return to IDLE.
- start while busy is ignored; it is neither queued nor restarted.
- ram_addr changes only in IDLE->SETUP and OUTPUT->SETUP transitions, never while ram_rd=1.
- Per-word latency with out_ready tied high: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.

Optional Feature:
- Macro: RAM_RD_CHECK_EN.
- When defined, the block adds:
  - Parameter EXP_OFFSET (default 5).
  - Outputs err_cnt [ADDR_W:0] and err_flag (1 bit).
  - Every captured word is compared with (EXP_OFFSET + out_addr) mod 2**DATA_W, matching the fill pattern used on the write side.
  - A mismatch increments err_cnt, which saturates at 16, and sets err_flag sticky.
  - Both are cleared by rst and by an accepted start.
- When not defined, the ports, parameter and logic are absent, and the sequencing is identical.

Decomposition:
- Package ram_rd_pkg holds:
  - The state enum: IDLE, SETUP, STROBE, HOLD, OUTPUT, DONE.
  - Default ADDR_W and DATA_W.
  - The depth constant.
- Sub-module ram_rd_timer: a loadable down-counter with a zero flag.
  - It is reused for the SETUP, STROBE and HOLD phase lengths.
  - It is loaded with (N-1) on phase entry.

Test Plan:
- Pre-fill addr i with 5+i, default parameters, out_ready=1. Send start with base=0, count=16 -> 16 words out in order 5,6,...,F,0,...,4 with out_addr 0..15. Each word takes 10 cycles, then a single done pulse.
- base=14, count=4 -> out_addr sequence 14,15,0,1. ram_addr never changes while ram_rd=1.
- count=0 -> done pulses 1 cycle after start. ram_rd stays 0 and out_valid stays 0.
- Hold out_ready=0 for 7 cycles on the 2nd word -> out_valid is held and out_data is stable. No new ram_rd occurs until the handshake.
- Pulse start mid-sweep, then assert rst during STROBE of word 3.
  - The start pulse is ignored.
  - rst returns all outputs to 0 the next cycle with no done pulse.
  - A new start then runs normally.
- With RAM_RD_CHECK_EN and addr 7 corrupted to 0 -> err_cnt=1 and err_flag=1 after the sweep. A new start clears both.
